// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared state codes, key codes and helpers for the ATM session controller
package atm_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 4'd0,
        PIN0     = 4'd1,
        PIN1     = 4'd2,
        PIN2     = 4'd3,
        PIN3     = 4'd4,
        PIN_FULL = 4'd5,
        CHECK    = 4'd6,
        MENU     = 4'd7,
        BAD_PIN  = 4'd8,
        LOCKED   = 4'd9,
        TIMEOUT  = 4'd10,
        EJECT    = 4'd11
    } state_t;

    localparam logic [3:0] KEY_ENTER  = 4'd10;
    localparam logic [3:0] KEY_CANCEL = 4'd11;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_down_timer.sv
// rtl/atm_down_timer.sv - loadable saturating down-counter with a done strobe on its last count
module atm_down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Clearing while idle guarantees a freshly entered state never sees a stale count of 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (!enable) begin
            count <= '0;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = enable && (count == WIDTH'(1));

endmodule

// File: rtl/atm_session_fsm.sv
// rtl/atm_session_fsm.sv - ATM front-panel session controller driving the status decoder
module atm_session_fsm
    import atm_pkg::*;
#(
    parameter logic [15:0] PIN            = 16'h1234,
    parameter int          MAX_TRIES      = 3,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          HOLD_CYCLES    = 50,
    parameter int          BLINK_CYCLES   = 25
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CARD,
    input  logic       KEY_VALID,
    input  logic [3:0] KEY,
    output logic       EN,
    output logic       W3,
    output logic       W2,
    output logic       W1,
    output logic       W0,
    output logic [1:0] TRIES_LEFT
);

    localparam int TMR_MAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int BLINK_W = $clog2(BLINK_CYCLES) + 1;

    state_t      state;
    state_t      prev_state;
    logic [15:0] pin_buf;
    logic        entered;
    logic        inact_state;
    logic        hold_state;
    logic        key_reload;
    logic        tmr_load;
    logic        tmr_done;
    logic [TMR_W-1:0] tmr_value;
    logic        blink_load;
    logic        blink_done;
    logic [BLINK_W-1:0] blink_value;
    logic [1:0]  tries_dec;

    assign {W3, W2, W1, W0} = state;

    // Entry is seen one cycle late, so entry loads are one short to keep exact dwell times.
    assign entered     = (state != prev_state);
    assign inact_state = (state >= PIN0 && state <= PIN_FULL) || state == MENU;
    assign hold_state  = (state == BAD_PIN) || (state == TIMEOUT);
    assign key_reload  = KEY_VALID && inact_state;
    assign tmr_load    = key_reload || entered;
    assign tmr_value   = key_reload ? TMR_W'(TIMEOUT_CYCLES)
                       : hold_state ? TMR_W'(HOLD_CYCLES - 1)
                       : TMR_W'(TIMEOUT_CYCLES - 1);

    assign blink_load  = blink_done || (state == LOCKED && entered);
    assign blink_value = blink_done ? BLINK_W'(BLINK_CYCLES) : BLINK_W'(BLINK_CYCLES - 1);

    assign tries_dec   = (TRIES_LEFT == 2'd0) ? 2'd0 : TRIES_LEFT - 2'd1;

    atm_down_timer #(.WIDTH(TMR_W)) u_session_timer (
        .clk        (CLK),
        .rst        (RST),
        .load       (tmr_load),
        .enable     (inact_state || hold_state),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

    atm_down_timer #(.WIDTH(BLINK_W)) u_blink_timer (
        .clk        (CLK),
        .rst        (RST),
        .load       (blink_load),
        .enable     (state == LOCKED),
        .load_value (blink_value),
        .done       (blink_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            prev_state <= IDLE;
            EN         <= 1'b1;
            TRIES_LEFT <= 2'(MAX_TRIES);
            pin_buf    <= '0;
        end else begin
            prev_state <= state;
            EN         <= 1'b1;
            case (state)
                IDLE: begin
                    if (CARD) begin
                        state      <= PIN0;
                        TRIES_LEFT <= 2'(MAX_TRIES);
                        pin_buf    <= '0;
                    end
                end
                PIN0, PIN1, PIN2, PIN3: begin
                    if (!CARD) begin
                        state <= IDLE;
                    end else if (KEY_VALID) begin
                        if (is_digit(KEY)) begin
                            pin_buf <= {pin_buf[11:0], KEY};
                            state   <= state_t'(state + 4'd1);
                        end else if (KEY == KEY_CANCEL) begin
                            state <= EJECT;
                        end
                    end else if (tmr_done) begin
                        state <= TIMEOUT;
                    end
                end
                PIN_FULL: begin
                    if (!CARD) begin
                        state <= IDLE;
                    end else if (KEY_VALID) begin
                        if (KEY == KEY_ENTER) begin
                            state <= CHECK;
                        end else if (KEY == KEY_CANCEL) begin
                            state <= EJECT;
                        end
                    end else if (tmr_done) begin
                        state <= TIMEOUT;
                    end
                end
                CHECK: begin
                    if (!CARD) begin
                        state <= IDLE;
                    end else if (pin_buf == PIN) begin
                        state      <= MENU;
                        TRIES_LEFT <= 2'(MAX_TRIES);
                    end else begin
                        TRIES_LEFT <= tries_dec;
                        state      <= (tries_dec == 2'd0) ? LOCKED : BAD_PIN;
                    end
                end
                MENU: begin
                    if (!CARD) begin
                        state <= IDLE;
                    end else if (KEY_VALID) begin
                        if (KEY == KEY_ENTER || KEY == KEY_CANCEL) begin
                            state <= EJECT;
                        end
                    end else if (tmr_done) begin
                        state <= TIMEOUT;
                    end
                end
                BAD_PIN: begin
                    if (!CARD) begin
                        state <= IDLE;
                    end else if (tmr_done) begin
                        state   <= PIN0;
                        pin_buf <= '0;
                    end
                end
                TIMEOUT: begin
                    if (!CARD) begin
                        state <= IDLE;
                    end else if (tmr_done) begin
                        state <= EJECT;
                    end
                end
                EJECT: begin
                    if (!CARD) begin
                        state <= IDLE;
                    end
                end
                LOCKED: begin
                    EN <= blink_done ? ~EN : EN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_session_fsm.sv
// tb/tb_atm_session_fsm.sv - scoreboard bench for the ATM session controller
module tb_atm_session_fsm;

    logic       clk;
    logic       rst;
    logic       card;
    logic       key_valid;
    logic [3:0] key;
    logic       en;
    logic       w3, w2, w1, w0;
    logic [1:0] tries_left;
    logic [3:0] w;

    int tests_run;
    int tests_failed;
    logic [3:0] exp_q[$];

    assign w = {w3, w2, w1, w0};

    atm_session_fsm dut (
        .CLK        (clk),
        .RST        (rst),
        .CARD       (card),
        .KEY_VALID  (key_valid),
        .KEY        (key),
        .EN         (en),
        .W3         (w3),
        .W2         (w2),
        .W1         (w1),
        .W0         (w0),
        .TRIES_LEFT (tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic step(input string tag, input logic [3:0] exp_w);
        logic [3:0] e;
        exp_q.push_back(exp_w);
        tick();
        e = exp_q.pop_front();
        check_val(tag, 32'(w), 32'(e));
    endtask

    task automatic press(input string tag, input logic [3:0] k, input logic [3:0] exp_w);
        key_valid = 1'b1;
        key       = k;
        exp_q.push_back(exp_w);
        tick();
        key_valid = 1'b0;
        key       = 4'd0;
        check_val(tag, 32'(w), 32'(exp_q.pop_front()));
    endtask

    task automatic enter_pin(input logic [15:0] pin, input logic [3:0] first_w);
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            d = pin[15 - 4*i -: 4];
            press("pin_digit", d, first_w + 4'(i) + 4'd1);
        end
        press("pin_enter", 4'd10, 4'd6);
    endtask

    task automatic wrong_then_bad(input logic [1:0] exp_tries);
        enter_pin(16'h1235, 4'd1);
        step("bad_pin", 4'd8);
        check_val("bad_tries", 32'(tries_left), 32'(exp_tries));
        idle(49);
        check_val("bad_hold", 32'(w), 32'd8);
        step("bad_to_pin0", 4'd1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1; card = 1'b0; key_valid = 1'b0; key = 4'd0;
        idle(2);
        check_val("rst_w", 32'(w), 32'd0);
        check_val("rst_en", 32'(en), 32'd1);
        check_val("rst_tries", 32'(tries_left), 32'd3);
        rst = 1'b0;

        // happy path
        card = 1'b1;
        step("card_in", 4'd1);
        enter_pin(16'h1234, 4'd1);
        step("menu", 4'd7);
        check_val("menu_tries", 32'(tries_left), 32'd3);
        press("menu_cancel", 4'd11, 4'd11);
        step("eject_hold", 4'd11);
        card = 1'b0;
        step("eject_out", 4'd0);

        // two wrong PINs then the right one
        card = 1'b1;
        step("card_in2", 4'd1);
        wrong_then_bad(2'd2);
        wrong_then_bad(2'd1);
        enter_pin(16'h1234, 4'd1);
        step("menu2", 4'd7);
        check_val("menu2_tries", 32'(tries_left), 32'd3);
        press("menu_enter", 4'd10, 4'd11);
        card = 1'b0;
        step("eject_out2", 4'd0);

        // lockout and blink
        card = 1'b1;
        step("card_in3", 4'd1);
        wrong_then_bad(2'd2);
        wrong_then_bad(2'd1);
        enter_pin(16'h1235, 4'd1);
        step("locked", 4'd9);
        check_val("locked_tries", 32'(tries_left), 32'd0);
        check_val("blink_entry", 32'(en), 32'd1);
        idle(24);
        check_val("blink_hi_end", 32'(en), 32'd1);
        tick();
        check_val("blink_lo", 32'(en), 32'd0);
        idle(24);
        check_val("blink_lo_end", 32'(en), 32'd0);
        tick();
        check_val("blink_hi2", 32'(en), 32'd1);
        card = 1'b0;
        step("locked_card", 4'd9);
        press("locked_key", 4'd11, 4'd9);
        rst = 1'b1;
        step("locked_rst", 4'd0);
        check_val("locked_rst_en", 32'(en), 32'd1);
        check_val("locked_rst_tries", 32'(tries_left), 32'd3);
        rst = 1'b0;

        // inactivity timeout
        card = 1'b1;
        step("card_in4", 4'd1);
        press("to_digit", 4'd1, 4'd2);
        idle(999);
        check_val("to_before", 32'(w), 32'd2);
        step("to_fire", 4'd10);
        idle(49);
        check_val("to_hold", 32'(w), 32'd10);
        step("to_eject", 4'd11);
        card = 1'b0;
        step("to_out", 4'd0);

        // key in the same cycle as expiry wins and reloads the timer
        card = 1'b1;
        step("card_in5", 4'd1);
        press("race_digit", 4'd1, 4'd2);
        idle(999);
        press("race_key", 4'd12, 4'd2);
        idle(999);
        check_val("race_reload", 32'(w), 32'd2);
        step("race_fire", 4'd10);
        card = 1'b0;
        step("to_card_out", 4'd0);

        // card pulled with a digit strobe in PIN2
        card = 1'b1;
        step("card_in6", 4'd1);
        press("p_d1", 4'd1, 4'd2);
        press("p_d2", 4'd2, 4'd3);
        card = 1'b0;
        press("pull_vs_key", 4'd3, 4'd0);

        // ignored keys, fifth digit, then reset from MENU
        card = 1'b1;
        step("card_in7", 4'd1);
        press("i_d1", 4'd1, 4'd2);
        press("i_d2", 4'd2, 4'd3);
        press("enter_ignored", 4'd10, 4'd3);
        for (int k = 12; k < 16; k++) press("code_ignored", 4'(k), 4'd3);
        press("i_d3", 4'd3, 4'd4);
        press("i_d4", 4'd4, 4'd5);
        press("fifth_digit", 4'd9, 4'd5);
        press("i_enter", 4'd10, 4'd6);
        step("buf_held_menu", 4'd7);
        press("menu_digit", 4'd5, 4'd7);
        rst = 1'b1;
        step("menu_rst", 4'd0);
        check_val("menu_rst_en", 32'(en), 32'd1);
        rst = 1'b0;
        step("restart", 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
